date_display_sched: RTL
=======================

Name: date_display_sched

Overview:
- Sequencer that time-shares the board's single 24-bit BCD date display path between four 24-bit date sources.
- Steps through the sources on a debounced push-button press, or automatically after a programmable dwell time.
- Blanks the display briefly between sources.
- Sits between the date constant/source logic and the six per-digit 7-segment decoders, which consume date_out[23:0] as six nibbles (HEX5 = [23:20] … HEX0 = [3:0]).

Parameters:
- TICK_DIV, 50000000, MAX10_CLK1_50 cycles per dwell tick (1 s at 50 MHz)
- DWELL_TICKS, 3, ticks spent in SHOW before auto-advance
- DEB_CYCLES, 500000, consecutive stable synchronized samples required to accept a key level change (10 ms)
- BLANK_CYC, 2500000, cycles spent in BLANK between sources

Ports:
- MAX10_CLK1_50  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- key_next_n  input  1  raw push-button, active-low, asynchronous, bouncy
- auto_en  input  1  slide switch, 1 = auto-rotate, asynchronous
- src0, src1, src2, src3  input  24 each  BCD date words, quasi-static
- date_out  output  24  registered date word to the digit decoders
- sel  output  2  index of the source currently shown
- disp_blank  output  1  1 = decoders must drive all segments off
- upd  output  1  one-cycle pulse when sel changes

Behaviour:
- Reset (async, RESET_N=0):
  - state=SHOW, sel=0, date_out=24'h000000, disp_blank=0, upd=0.
  - All counters = 0; debounced key level = 1 (released); synchronizers = 1 (key) / 0 (auto_en).
- Synchronization:
  - key_next_n and auto_en each pass through 2-FF synchronizers.
  - The debounce counter increments while the synchronized key differs from the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - press = debounced 1->0 transition; a single-cycle event.
  - Release generates nothing.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; tick = 1 cycle when it wraps.
  - Runs regardless of state.
- Dwell counter:
  - Counts ticks only in SHOW with synchronized auto_en=1.
  - Cleared on every advance and whenever synchronized auto_en=0.
  - expire = (dwell == DWELL_TICKS-1) && tick.
- State SHOW:
  - date_out <= src[sel] every cycle (1-cycle latency, tracks source changes).
  - disp_blank=0.
  - advance = press || expire; press and expire in the same cycle produce exactly one advance.
  - On advance: -> BLANK, blank counter cleared, dwell cleared.
- State BLANK:
  - disp_blank=1; date_out holds its last value.
  - press events in BLANK are discarded, not queued; dwell is frozen at 0.
  - After exactly BLANK_CYC cycles in BLANK: sel <= sel+1 (wraps 3->0), date_out <= src[sel+1], upd=1 for that one cycle, disp_blank=0, -> SHOW.
- Reset mid-BLANK:
  - Immediate return to reset values; the pending advance is lost.
- Width rules:
  - Counters sized with $clog2 of their parameter; no overflow is possible by construction.
  - sel arithmetic is modulo 4.

Optional Feature:
- Macro: DATE_SCHED_PREV_KEY_EN.
- When defined:
  - Adds input key_prev_n (1 bit, active-low), with its own synchronizer and debouncer identical to key_next_n.
  - A debounced press goes SHOW->BLANK with direction=backward; the BLANK exit then sets sel <= sel-1 (wraps 0->3).
  - Simultaneous next and prev presses in the same cycle: next wins.
  - Auto-advance is always forward.
- When undefined: the port, its logic and the direction flag are absent; only forward stepping exists.

Test Plan (TICK_DIV=10, DWELL_TICKS=3, DEB_CYCLES=4, BLANK_CYC=2, src0=24'h051800, src1=24'h030170, src2=24'h123199, src3=24'h070400):
- Reset pulse, auto_en=0, key high -> date_out=24'h000000 during reset; 24'h051800, sel=0, disp_blank=0 one cycle after release; no upd for 100 cycles.
- key_next_n low for 10 cycles -> disp_blank=1 for exactly 2 cycles; then sel=1, date_out=24'h030170, single upd pulse; exactly one advance.
- key_next_n low 2 cycles, high 2, low 2, then high -> no advance; sel stays 0 and disp_blank stays 0.
- auto_en=1, key idle for 200 cycles -> sel sequence 0,1,2,3,0; SHOW lasts 3 ticks, then 2 blank cycles per step; date_out=24'h070400 when sel=3; wrap 3->0 gives 24'h051800.
- Second debounced press arriving during BLANK -> ignored; only one sel increment. Press landing in the same cycle as auto expire -> one increment.
- RESET_N low while disp_blank=1 with sel=2 -> sel=0, disp_blank=0, upd=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/date_display_sched.sv
// Date display sequencer: rotates four BCD date sources onto one display path, with a blanking gap between sources.
// Optional backward-step key enabled by defining DATE_SCHED_PREV_KEY_EN.

module DateKeyDebounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1_q, sync_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      sync_q <= 1'b1;
      deb_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= key_n_i;
      sync_q <= s1_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // The level flips on the DEB_CYCLES-th consecutive differing sample; only the falling flip is a press.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_o = 1'b0;
    if (sync_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d   = sync_q;
        press_o = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

module date_display_sched #(
  parameter int TICK_DIV    = 50000000,
  parameter int DWELL_TICKS = 3,
  parameter int DEB_CYCLES  = 500000,
  parameter int BLANK_CYC   = 2500000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        RESET_N,
  input  logic        key_next_n,
`ifdef DATE_SCHED_PREV_KEY_EN
  input  logic        key_prev_n,
`endif
  input  logic        auto_en,
  input  logic [23:0] src0,
  input  logic [23:0] src1,
  input  logic [23:0] src2,
  input  logic [23:0] src3,
  output logic [23:0] date_out,
  output logic [1:0]  sel,
  output logic        disp_blank,
  output logic        upd
);

  localparam int TW  = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int DWW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW  = (BLANK_CYC > 1)   ? $clog2(BLANK_CYC)   : 1;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q, sel_d, selStep;
  logic [23:0]    date_q, date_d;
  logic           upd_q, upd_d;
  logic           autoS1_q, autoSync_q;
  logic [TW-1:0]  presc_q;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [BW-1:0]  blank_q, blank_d;
  logic           tick, expire, advance, pressNext, pressPrev;
  logic [23:0]    srcArr [4];

  assign srcArr[0] = src0;
  assign srcArr[1] = src1;
  assign srcArr[2] = src2;
  assign srcArr[3] = src3;

  DateKeyDebounce #(.DEB_CYCLES(DEB_CYCLES)) uNextDeb (
    .clk_i   (MAX10_CLK1_50),
    .rst_ni  (RESET_N),
    .key_n_i (key_next_n),
    .press_o (pressNext)
  );

`ifdef DATE_SCHED_PREV_KEY_EN
  logic dirBack_q, dirBack_d;

  DateKeyDebounce #(.DEB_CYCLES(DEB_CYCLES)) uPrevDeb (
    .clk_i   (MAX10_CLK1_50),
    .rst_ni  (RESET_N),
    .key_n_i (key_prev_n),
    .press_o (pressPrev)
  );

  assign selStep = dirBack_q ? (sel_q - 2'd1) : (sel_q + 2'd1);
`else
  assign pressPrev = 1'b0;
  assign selStep   = sel_q + 2'd1;
`endif

  assign tick    = (presc_q == TW'(TICK_DIV - 1));
  assign expire  = (state_q == SHOW) && autoSync_q && tick && (dwell_q == DWW'(DWELL_TICKS - 1));
  assign advance = (state_q == SHOW) && (pressNext || pressPrev || expire);

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= SHOW;
      sel_q      <= 2'd0;
      date_q     <= 24'h000000;
      upd_q      <= 1'b0;
      autoS1_q   <= 1'b0;
      autoSync_q <= 1'b0;
      presc_q    <= '0;
      dwell_q    <= '0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      date_q     <= date_d;
      upd_q      <= upd_d;
      autoS1_q   <= auto_en;
      autoSync_q <= autoS1_q;
      presc_q    <= tick ? '0 : presc_q + 1'b1;
      dwell_q    <= dwell_d;
      blank_q    <= blank_d;
    end
  end

`ifdef DATE_SCHED_PREV_KEY_EN
  // Direction is latched at the advance and consumed at the BLANK exit; next and auto always step forward.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      dirBack_q <= 1'b0;
    end else begin
      dirBack_q <= dirBack_d;
    end
  end

  always_comb begin
    dirBack_d = dirBack_q;
    if (advance) begin
      dirBack_d = pressPrev && !pressNext;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    date_d  = date_q;
    upd_d   = 1'b0;
    dwell_d = dwell_q;
    blank_d = blank_q;
    case (state_q)
      SHOW: begin
        date_d = srcArr[sel_q];
        if (advance) begin
          state_d = BLANK;
          blank_d = '0;
          dwell_d = '0;
        end else if (!autoSync_q) begin
          dwell_d = '0;
        end else if (tick) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      BLANK: begin
        // Presses here are simply not looked at, so they are dropped rather than queued.
        dwell_d = '0;
        if (blank_q == BW'(BLANK_CYC - 1)) begin
          state_d = SHOW;
          sel_d   = selStep;
          date_d  = srcArr[selStep];
          upd_d   = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  assign date_out   = date_q;
  assign sel        = sel_q;
  assign disp_blank = (state_q == BLANK);
  assign upd        = upd_q;

endmodule
